// File: rtl/xpb_table_gen.sv
// Streams T[i] = (i*B) mod M, i = 0 .. 2^SEL_BITS-1, into an external table RAM.
// One modular accumulate per entry: the add and the conditional subtract sit in separate cycles.
module xpb_table_gen #(
    parameter int WORD_BITS = 1024,
    parameter int SEL_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] base_in,
    input  logic [WORD_BITS-1:0] modulus_in,
    output logic                 busy,
    output logic                 wr_en,
    output logic [SEL_BITS-1:0]  wr_addr,
    output logic [WORD_BITS-1:0] wr_data,
    output logic                 done
);

    typedef enum logic [2:0] {IDLE, WR0, ADD, RED, FIN} state_t;

    localparam logic [SEL_BITS-1:0] LAST_IDX = '1;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] b_q, b_d;
    logic [WORD_BITS-1:0] m_q, m_d;
    logic [WORD_BITS-1:0] acc_q, acc_d;
    logic [WORD_BITS:0]   sum_q, sum_d;
    logic [SEL_BITS-1:0]  idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 wr_en_q, wr_en_d;
    logic [SEL_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_BITS-1:0] wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic [WORD_BITS-1:0] diff;
    logic [WORD_BITS-1:0] red;

    // The low bits of sum - M are exact whenever sum >= M, so the subtract stays WORD_BITS wide.
    assign diff = sum_q[WORD_BITS-1:0] - m_q;
    assign red  = (sum_q >= {1'b0, m_q}) ? diff : sum_q[WORD_BITS-1:0];

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
        state_d   = state_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Sum is captured at the end of WR0/RED, when acc_q already holds the latest entry.
        sum_d     = {1'b0, acc_q} + {1'b0, b_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    b_d       = base_in;
                    m_d       = modulus_in;
                    acc_d     = '0;
                    idx_d     = '0;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    state_d   = WR0;
                end
            end
            WR0: begin
                idx_d   = SEL_BITS'(1);
                state_d = ADD;
            end
            ADD: begin
                acc_d     = red;
                wr_addr_d = idx_q;
                wr_data_d = red;
                state_d   = RED;
            end
            RED: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + SEL_BITS'(1);
                    state_d = ADD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        wr_en_d = (state_d == WR0) || (state_d == RED);
        busy_d  = (state_d == WR0) || (state_d == ADD) || (state_d == RED);
        done_d  = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench: an 8-bit/16-entry instance driven from a vector table, and a default-size
// instance checked against a wide (i*B)%M model; both run back-to-back with cycle-exact timing.
module tb_xpb_table_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: WORD_BITS=8, SEL_BITS=4
    logic        rst_a, start_a, busy_a, wr_en_a, done_a;
    logic [7:0]  base_a, mod_a, wr_data_a;
    logic [3:0]  wr_addr_a;

    // Default instance: WORD_BITS=1024, SEL_BITS=5
    logic          rst_b, start_b, busy_b, wr_en_b, done_b;
    logic [1023:0] base_b, mod_b, wr_data_b;
    logic [4:0]    wr_addr_b;

    xpb_table_gen #(.WORD_BITS(8), .SEL_BITS(4)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .base_in(base_a), .modulus_in(mod_a),
        .busy(busy_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .done(done_a)
    );

    xpb_table_gen dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .base_in(base_b), .modulus_in(mod_b),
        .busy(busy_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .done(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]       b;
        logic [7:0]       m;
        logic [15:0][7:0] exp;   // exp[i] = T[i]
    } vec_t;

    vec_t vecs[4];

    logic [3:0]    last_addr_a;
    logic [7:0]    last_data_a;
    logic [4:0]    last_addr_b;
    logic [1023:0] last_data_b;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge (that cycle is cycle 0); returns at the negedge of cycle 33,
    // the cycle after done, so consecutive calls are back-to-back runs.
    task automatic run_a(input vec_t v, input int tag);
        logic wr;
        base_a  = v.b;
        mod_a   = v.m;
        start_a = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
            wr = (c == 1) || ((c % 2 == 1) && (c <= 31));
            if (wr) begin
                last_addr_a = 4'((c - 1) / 2);
                last_data_a = v.exp[(c - 1) / 2];
            end
            check($sformatf("a%0d.wr_en c%0d", tag, c), wr_en_a, wr);
            check($sformatf("a%0d.wr_addr c%0d", tag, c), wr_addr_a, last_addr_a);
            check($sformatf("a%0d.wr_data c%0d", tag, c), wr_data_a, last_data_a);
            check($sformatf("a%0d.busy c%0d", tag, c), busy_a, c <= 31);
            check($sformatf("a%0d.done c%0d", tag, c), done_a, c == 32);
        end
    endtask

    function automatic logic [1023:0] model(input logic [1023:0] b, input logic [1023:0] m, input int i);
        logic [1031:0] p;
        p = ({8'd0, b} * 1032'(i)) % {8'd0, m};
        return p[1023:0];
    endfunction

    // Same framing as run_a for the default size: writes in cycles 1,3..63, done in 64.
    // With disturb set, start is re-pulsed and the inputs change mid-run.
    task automatic run_b(input logic [1023:0] b, input logic [1023:0] m, input bit disturb, input int tag);
        logic wr;
        base_b  = b;
        mod_b   = m;
        start_b = 1'b1;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            if (disturb && c == 20) begin
                start_b = 1'b1;
                base_b  = ~b;
                mod_b   = m ^ 1024'd2;
            end
            if (disturb && c == 21) start_b = 1'b0;
            wr = (c == 1) || ((c % 2 == 1) && (c <= 63));
            if (wr) begin
                last_addr_b = 5'((c - 1) / 2);
                last_data_b = model(b, m, (c - 1) / 2);
            end
            check($sformatf("b%0d.wr_en c%0d", tag, c), wr_en_b, wr);
            check($sformatf("b%0d.wr_addr c%0d", tag, c), wr_addr_b, last_addr_b);
            check($sformatf("b%0d.wr_data c%0d", tag, c), wr_data_b, last_data_b);
            check($sformatf("b%0d.busy c%0d", tag, c), busy_b, c <= 63);
            check($sformatf("b%0d.done c%0d", tag, c), done_b, c == 64);
        end
    endtask

    initial begin
        logic [1023:0] rm, rb;

        vecs[0].b = 8'd5;    vecs[0].m = 8'd13;
        vecs[0].exp = {8'd10, 8'd5, 8'd0, 8'd8, 8'd3, 8'd11, 8'd6, 8'd1,
                       8'd9, 8'd4, 8'd12, 8'd7, 8'd2, 8'd10, 8'd5, 8'd0};
        vecs[1].b = 8'hFE;   vecs[1].m = 8'hFF;
        vecs[1].exp = {8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7,
                       8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'h00};
        vecs[2].b = 8'd0;    vecs[2].m = 8'd13;   vecs[2].exp = '0;
        vecs[3].b = 8'd0;    vecs[3].m = 8'd1;    vecs[3].exp = '0;

        rst_a = 1'b1; start_a = 1'b0; base_a = '0; mod_a = '0;
        rst_b = 1'b1; start_b = 1'b0; base_b = '0; mod_b = '0;
        last_addr_a = '0; last_data_a = '0; last_addr_b = '0; last_data_b = '0;
        repeat (3) @(negedge clk);

        check("a.reset busy", busy_a, 1'b0);
        check("a.reset wr_en", wr_en_a, 1'b0);
        check("a.reset wr_addr", wr_addr_a, 4'd0);
        check("a.reset wr_data", wr_data_a, 8'd0);
        check("a.reset done", done_a, 1'b0);
        check("b.reset busy", busy_b, 1'b0);
        check("b.reset wr_en", wr_en_b, 1'b0);
        check("b.reset done", done_b, 1'b0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back (each start lands in the cycle after done)
        for (int v = 0; v < 4; v++) run_a(vecs[v], v);

        // Reset asserted in cycle 10 of a run: outputs drop next cycle, no done ever follows
        base_a  = vecs[0].b;
        mod_a   = vecs[0].m;
        start_a = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
        end
        rst_a = 1'b1;
        @(negedge clk);
        check("rst.wr_en c11", wr_en_a, 1'b0);
        check("rst.busy c11", busy_a, 1'b0);
        check("rst.done c11", done_a, 1'b0);
        rst_a = 1'b0;
        for (int c = 12; c <= 50; c++) begin
            @(negedge clk);
            check($sformatf("rst.wr_en c%0d", c), wr_en_a, 1'b0);
            check($sformatf("rst.done c%0d", c), done_a, 1'b0);
            check($sformatf("rst.busy c%0d", c), busy_a, 1'b0);
        end
        last_addr_a = '0;
        last_data_a = '0;
        run_a(vecs[0], 10);

        // Default size: carry-sensitive 16-bit values, random operands with a mid-run start,
        // B=0, and M=1 -- all back-to-back
        run_b(1024'h8000, 1024'hFFF1, 1'b0, 0);
        check("b0.T4 hand", model(1024'h8000, 1024'hFFF1, 4), 1024'h001E);
        for (int w = 0; w < 32; w++) rm[w*32 +: 32] = $urandom;
        rm[1023] = 1'b1;
        for (int w = 0; w < 32; w++) rb[w*32 +: 32] = $urandom;
        rb = rb % rm;
        run_b(rb, rm, 1'b1, 1);
        run_b('0, rm, 1'b0, 2);
        run_b('0, 1024'd1, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
